// File: rtl/vend_sched.sv
// Two-panel vending scheduler: per-panel coin credit, one shared dispenser
// arbitrated round robin, cancel/refund, and change delivery after each vend.
module vend_sched #(
    parameter int unsigned DISP_CYC = 4,
    parameter logic [5:0]  PRICE0   = 6'd5,
    parameter logic [5:0]  PRICE1   = 6'd10,
    parameter logic [5:0]  PRICE2   = 6'd15,
    parameter logic [5:0]  PRICE3   = 6'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] prod0,
    input  logic [1:0] prod1,
    input  logic [1:0] coin_vld,
    input  logic [4:0] coin0,
    input  logic [4:0] coin1,
    input  logic [1:0] cancel,
    output logic [5:0] credit0,
    output logic [5:0] credit1,
    output logic [1:0] coin_rej,
    output logic [1:0] grant,
    output logic       vend,
    output logic [1:0] vend_prod,
    output logic       change_vld,
    output logic       change_port,
    output logic [5:0] change_amt,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, DISPENSE, CHANGE} state_t;

    state_t     state;
    logic [3:0] cnt;        // dispense cycles still to go after the current one
    logic       ptr;        // panel that wins when both are eligible
    logic       sel;        // panel owning the current vend
    logic [1:0] prod_lat;   // product captured at grant time

    logic [5:0] cr     [2];
    logic [1:0] pd     [2];
    logic [4:0] cn     [2];
    logic [6:0] sum    [2];
    logic [5:0] nxt_cr [2];
    logic [1:0] elig;
    logic [1:0] cxl;
    logic [1:0] blocked;
    logic [1:0] accept;
    logic       do_cancel;
    logic       cancel_port;
    logic       do_grant;
    logic       grant_port;

    function automatic logic [5:0] price_of(input logic [1:0] p);
        case (p)
            2'd0:    price_of = PRICE0;
            2'd1:    price_of = PRICE1;
            2'd2:    price_of = PRICE2;
            default: price_of = PRICE3;
        endcase
    endfunction

    // Arbitration decisions and next credit per panel (coins, vend charge, clears)
    always_comb begin
        cr[0] = credit0;
        cr[1] = credit1;
        pd[0] = prod0;
        pd[1] = prod1;
        cn[0] = coin0;
        cn[1] = coin1;
        elig    = '0;
        cxl     = '0;
        blocked = '0;
        accept  = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i]    = (state == IDLE) && req[i] && !cancel[i] && (cr[i] >= price_of(pd[i]));
            cxl[i]     = (state == IDLE) && cancel[i] && (cr[i] != 6'd0);
            blocked[i] = grant[i] || ((state == CHANGE) && (change_port == 1'(i)))
                         || ((state == IDLE) && cancel[i]);
            sum[i]     = {1'b0, cr[i]} + {2'b00, cn[i]};
            accept[i]  = coin_vld[i] && !blocked[i] && (sum[i] <= 7'd63);
            nxt_cr[i]  = accept[i] ? sum[i][5:0] : cr[i];
        end
        do_cancel   = |cxl;
        cancel_port = !cxl[0];
        do_grant    = !do_cancel && (|elig);
        grant_port  = (elig == 2'b11) ? ptr : elig[1];
        // A refund or a vend charge applies to the panel being served this edge
        if (do_cancel) begin
            nxt_cr[cancel_port] = 6'd0;
        end else if (do_grant) begin
            nxt_cr[grant_port] = nxt_cr[grant_port] - price_of(pd[grant_port]);
        end
        // The served panel's leftover credit leaves as change on the last dispense cycle
        if ((state == DISPENSE) && (cnt == 4'd0)) begin
            nxt_cr[sel] = 6'd0;
        end
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ptr         <= 1'b0;
            sel         <= 1'b0;
            prod_lat    <= 2'd0;
            credit0     <= 6'd0;
            credit1     <= 6'd0;
            coin_rej    <= 2'b00;
            grant       <= 2'b00;
            vend        <= 1'b0;
            vend_prod   <= 2'd0;
            change_vld  <= 1'b0;
            change_port <= 1'b0;
            change_amt  <= 6'd0;
            busy        <= 1'b0;
        end else begin
            credit0    <= nxt_cr[0];
            credit1    <= nxt_cr[1];
            coin_rej   <= coin_vld & ~accept;
            change_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_cancel) begin
                        state       <= CHANGE;
                        change_vld  <= 1'b1;
                        change_port <= cancel_port;
                        change_amt  <= cr[cancel_port];
                        busy        <= 1'b1;
                    end else if (do_grant) begin
                        state    <= GRANT;
                        grant    <= grant_port ? 2'b10 : 2'b01;
                        sel      <= grant_port;
                        prod_lat <= pd[grant_port];
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    state     <= DISPENSE;
                    vend      <= 1'b1;
                    vend_prod <= prod_lat;
                    cnt       <= 4'(DISP_CYC - 1);
                end
                DISPENSE: begin
                    if (cnt == 4'd0) begin
                        state       <= CHANGE;
                        vend        <= 1'b0;
                        grant       <= 2'b00;
                        change_vld  <= 1'b1;
                        change_port <= sel;
                        change_amt  <= cr[sel];
                        ptr         <= ~sel;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CHANGE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sched.sv
// Bench for vend_sched: a transaction-timeline model of the two panels is
// compared against the DUT every cycle, and directed scenarios carry
// hand-computed literal expectations.
module tb_vend_sched;

    localparam int DISP = 4;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] prod0, prod1;
    logic [1:0] coin_vld;
    logic [4:0] coin0, coin1;
    logic [1:0] cancel;
    logic [5:0] credit0, credit1;
    logic [1:0] coin_rej;
    logic [1:0] grant;
    logic       vend;
    logic [1:0] vend_prod;
    logic       change_vld;
    logic       change_port;
    logic [5:0] change_amt;
    logic       busy;

    vend_sched #(.DISP_CYC(DISP)) dut (
        .clk(clk), .rst(rst), .req(req), .prod0(prod0), .prod1(prod1),
        .coin_vld(coin_vld), .coin0(coin0), .coin1(coin1), .cancel(cancel),
        .credit0(credit0), .credit1(credit1), .coin_rej(coin_rej), .grant(grant),
        .vend(vend), .vend_prod(vend_prod), .change_vld(change_vld),
        .change_port(change_port), .change_amt(change_amt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is either a vend or a refund; m_t counts cycles since it
    // started (1 = first cycle after the deciding IDLE cycle).
    int m_cr[2];
    int m_ptr;
    bit m_act;
    bit m_refund;
    int m_port;
    int m_t;
    int m_prod;
    int m_chg;
    int e_rej;
    int e_grant;
    bit e_vend;
    bit e_chg;

    function automatic int price(input int p);
        case (p)
            0: return 5;
            1: return 10;
            2: return 15;
            default: return 20;
        endcase
    endfunction

    task automatic update_exp();
        e_grant = (m_act && !m_refund && m_t <= DISP + 1) ? (1 << m_port) : 0;
        e_vend  = m_act && !m_refund && m_t >= 2 && m_t <= DISP + 1;
        e_chg   = m_act && (m_refund ? 1'b1 : (m_t == DISP + 2));
    endtask

    task automatic model_reset();
        m_cr[0] = 0; m_cr[1] = 0;
        m_ptr = 0; m_act = 0; m_refund = 0; m_port = 0; m_t = 0;
        m_prod = 0; m_chg = 0; e_rej = 0;
        update_exp();
    endtask

    task automatic model_step();
        int  coinv[2];
        int  pr[2];
        bit  blk[2];
        bit  el[2];
        bit  cx[2];
        int  p;
        if (rst) begin
            model_reset();
            return;
        end
        coinv[0] = coin0; coinv[1] = coin1;
        pr[0] = prod0;    pr[1] = prod1;
        for (int i = 0; i < 2; i++) begin
            blk[i] = m_act ? (m_port == i) : cancel[i];
            el[i]  = !m_act && req[i] && !cancel[i] && m_cr[i] >= price(pr[i]);
            cx[i]  = !m_act && cancel[i] && m_cr[i] > 0;
        end
        e_rej = 0;
        for (int i = 0; i < 2; i++) begin
            if (coin_vld[i]) begin
                if (!blk[i] && m_cr[i] + coinv[i] <= 63) m_cr[i] += coinv[i];
                else e_rej |= (1 << i);
            end
        end
        if (!m_act) begin
            if (cx[0] || cx[1]) begin
                p = cx[0] ? 0 : 1;
                m_act = 1; m_refund = 1; m_port = p; m_t = 1;
                m_chg = m_cr[p]; m_cr[p] = 0;
            end else if (el[0] || el[1]) begin
                p = (el[0] && el[1]) ? m_ptr : (el[0] ? 0 : 1);
                m_act = 1; m_refund = 0; m_port = p; m_t = 1;
                m_prod = pr[p]; m_cr[p] -= price(pr[p]);
            end
        end else if (m_refund) begin
            m_act = 0;
        end else if (m_t == DISP + 1) begin
            m_chg = m_cr[m_port]; m_cr[m_port] = 0; m_ptr = 1 - m_port; m_t++;
        end else if (m_t == DISP + 2) begin
            m_act = 0;
        end else begin
            m_t++;
        end
        update_exp();
    endtask

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("credit0", credit0, m_cr[0]);
            chk("credit1", credit1, m_cr[1]);
            chk("coin_rej", coin_rej, e_rej);
            chk("grant", grant, e_grant);
            chk("vend", vend, e_vend);
            chk("change_vld", change_vld, e_chg);
            chk("busy", busy, m_act);
            if (e_vend) chk("vend_prod", vend_prod, m_prod);
            if (e_chg) begin
                chk("change_port", change_port, m_port);
                chk("change_amt", change_amt, m_chg);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        req = 0; prod0 = 0; prod1 = 0; coin_vld = 0; coin0 = 0; coin1 = 0; cancel = 0;
    endtask

    task automatic put_coin(input int p, input int v);
        coin_vld = 2'(1 << p);
        if (p == 0) coin0 = 5'(v); else coin1 = 5'(v);
        cycle();
        coin_vld = 0; coin0 = 0; coin1 = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        cmp_en = 1;
        chk("rst_credit0", credit0, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_change_amt", change_amt, 0);

        // Panel 0: coin 5, product 0, no change
        put_coin(0, 5);
        chk("t1_credit0", credit0, 5);
        req = 2'b01; prod0 = 2'd0;
        cycle();
        idle_in();
        chk("t1_grant", grant, 1);
        chk("t1_credit0_charged", credit0, 0);
        cycle();
        chk("t1_vend_first", vend, 1);
        chk("t1_vend_prod", vend_prod, 0);
        repeat (3) cycle();
        chk("t1_vend_last", vend, 1);
        cycle();
        chk("t1_change_vld", change_vld, 1);
        chk("t1_change_port", change_port, 0);
        chk("t1_change_amt", change_amt, 0);
        chk("t1_vend_off", vend, 0);
        cycle();
        chk("t1_busy_off", busy, 0);

        // Panel 1: 10+10, product 2, change 5
        put_coin(1, 10);
        put_coin(1, 10);
        req = 2'b10; prod1 = 2'd2;
        cycle();
        idle_in();
        chk("t2_grant", grant, 2);
        chk("t2_credit1", credit1, 5);
        cycle();
        chk("t2_vend_prod", vend_prod, 2);
        repeat (3) cycle();
        cycle();
        chk("t2_change_port", change_port, 1);
        chk("t2_change_amt", change_amt, 5);
        chk("t2_credit1_cleared", credit1, 0);
        cycle();

        // Both panels funded from reset: panel 0 first, then panel 1
        apply_reset();
        coin_vld = 2'b11; coin0 = 5'd20; coin1 = 5'd20;
        cycle();
        idle_in();
        req = 2'b11; prod0 = 0; prod1 = 0;
        cycle();
        chk("t3_grant0", grant, 1);
        chk("t3_credit0", credit0, 15);
        chk("t3_credit1", credit1, 20);
        repeat (4) cycle();
        cycle();
        chk("t3_change0_port", change_port, 0);
        chk("t3_change0_amt", change_amt, 15);
        cycle();
        cycle();
        chk("t3_grant1", grant, 2);
        chk("t3_credit1_charged", credit1, 15);
        idle_in();
        repeat (4) cycle();
        cycle();
        chk("t3_change1_port", change_port, 1);
        chk("t3_change1_amt", change_amt, 15);
        cycle();

        // Overflow reject, then panel 1 coin accepted during panel 0 dispense
        put_coin(0, 20);
        put_coin(0, 20);
        put_coin(0, 10);
        put_coin(0, 20);
        chk("t4_coin_rej", coin_rej, 1);
        chk("t4_credit0_kept", credit0, 50);
        req = 2'b01; prod0 = 2'd3;
        cycle();
        idle_in();
        chk("t4_credit0_charged", credit0, 30);
        cycle();
        put_coin(1, 10);
        chk("t4_credit1_during_vend", credit1, 10);
        chk("t4_coin_rej_clear", coin_rej, 0);
        repeat (2) cycle();
        cycle();
        chk("t4_change_amt", change_amt, 30);
        cycle();

        // Cancel beats a simultaneous request
        put_coin(0, 10);
        put_coin(0, 2);
        cancel = 2'b01; req = 2'b01; prod0 = 0;
        cycle();
        idle_in();
        chk("t5_change_vld", change_vld, 1);
        chk("t5_change_amt", change_amt, 12);
        chk("t5_grant", grant, 0);
        chk("t5_credit0", credit0, 0);
        cycle();
        // Both cancel; panel 0 has nothing so panel 1 is refunded
        cancel = 2'b11;
        cycle();
        idle_in();
        chk("t5_refund1_port", change_port, 1);
        chk("t5_refund1_amt", change_amt, 10);
        cycle();

        // Reset in the second vend cycle
        put_coin(0, 20);
        put_coin(1, 7);
        req = 2'b01; prod0 = 2'd1;
        cycle();
        idle_in();
        cycle();
        cycle();
        chk("t6_vend_before_rst", vend, 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_vend_rst", vend, 0);
        chk("t6_credit0_rst", credit0, 0);
        chk("t6_credit1_rst", credit1, 0);
        chk("t6_grant_rst", grant, 0);
        cycle();
        rst = 1'b0;
        repeat (8) cycle();
        put_coin(1, 5);
        req = 2'b10; prod1 = 2'd0;
        cycle();
        idle_in();
        chk("t6_resume_grant", grant, 2);
        repeat (6) cycle();

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
